// File: rtl/note_envelope_if.sv
// rtl/note_envelope_if.sv - sample stream handshake bundle between summer, envelope and truncator
interface note_envelope_if #(
  parameter int DATA_WIDTH = 20
);

  logic signed [DATA_WIDTH-1:0] sample_in;
  logic                         sample_in_valid;
  logic                         sample_in_ready;
  logic signed [DATA_WIDTH-1:0] sample_out;
  logic                         sample_out_valid;
  logic                         sample_out_ready;

  // Upstream/downstream side that feeds samples in and drains them out
  modport master (
    output sample_in,
    output sample_in_valid,
    input  sample_in_ready,
    input  sample_out,
    input  sample_out_valid,
    output sample_out_ready
  );

  // Envelope block side
  modport slave (
    input  sample_in,
    input  sample_in_valid,
    output sample_in_ready,
    output sample_out,
    output sample_out_valid,
    input  sample_out_ready
  );

endinterface

// File: rtl/note_envelope.sv
// rtl/note_envelope.sv - per-note ADSR amplitude envelope applied to the summed NCO sample stream
module note_envelope #(
  parameter int DATA_WIDTH = 20,
  parameter int ENV_WIDTH  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  note_envelope_if.slave       s_if,
  input  logic                 note_start,
  input  logic                 note_release,
  input  logic                 note_reset,
  input  logic [ENV_WIDTH-1:0] attack_step,
  input  logic [ENV_WIDTH-1:0] decay_step,
  input  logic [ENV_WIDTH-1:0] sustain_level,
  input  logic [ENV_WIDTH-1:0] release_step,
  output logic [ENV_WIDTH-1:0] level,
  output logic [2:0]           state,
  output logic                 note_finished
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam int PROD_WIDTH = DATA_WIDTH + ENV_WIDTH + 1;
  localparam logic [ENV_WIDTH-1:0] LEVEL_MAX = '1;

  logic [2:0]                   state_q, state_d;
  logic [ENV_WIDTH-1:0]         level_q, level_d;
  logic                         finished_q, finished_d;
  logic signed [DATA_WIDTH-1:0] sample_out_q, sample_out_d;
  logic                         out_valid_q, out_valid_d;

  logic                         in_ready;
  logic                         accept;

  logic signed [PROD_WIDTH-1:0] mul_a;
  logic signed [PROD_WIDTH-1:0] mul_b;
  logic signed [PROD_WIDTH-1:0] prod;
  logic                         unused_prod;

  logic [ENV_WIDTH:0]           attack_sum;
  logic [ENV_WIDTH:0]           decay_floor;

  // A new sample may enter whenever the output slot is empty or being drained this cycle
  always_comb begin
    in_ready = !out_valid_q || s_if.sample_out_ready;
    accept   = s_if.sample_in_valid && in_ready;
  end

  // Signed sample times unsigned level; taking the slice above the fraction bits
  // of a two's-complement product is an arithmetic shift, i.e. floor division.
  always_comb begin
    mul_a        = {{(PROD_WIDTH - DATA_WIDTH){s_if.sample_in[DATA_WIDTH-1]}}, s_if.sample_in};
    mul_b        = {{(PROD_WIDTH - ENV_WIDTH){1'b0}}, level_q};
    prod         = mul_a * mul_b;
    sample_out_d = prod[ENV_WIDTH +: DATA_WIDTH];
    unused_prod  = ^{prod[PROD_WIDTH-1:ENV_WIDTH+DATA_WIDTH], prod[ENV_WIDTH-1:0]};
  end

  // Output slot: load on accept, empty when drained with nothing behind it, else hold
  always_comb begin
    out_valid_d = out_valid_q;
    if (accept) begin
      out_valid_d = 1'b1;
    end else if (s_if.sample_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Saturation helpers computed one bit wider so the carry/borrow is visible
  always_comb begin
    attack_sum  = {1'b0, level_q} + {1'b0, attack_step};
    decay_floor = {1'b0, sustain_level} + {1'b0, decay_step};
  end

  // Envelope next state: control pulses first, otherwise one step per accepted sample
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    finished_d = finished_q;

    if (note_reset) begin
      state_d    = ST_IDLE;
      level_d    = '0;
      finished_d = 1'b0;
    end else if (note_start) begin
      // Retrigger keeps the current level so there is no audible click
      state_d    = ST_ATTACK;
      finished_d = 1'b0;
    end else if (note_release) begin
      if ((state_q == ST_ATTACK) || (state_q == ST_DECAY) || (state_q == ST_SUSTAIN)) begin
        state_d = ST_RELEASE;
      end
    end else if (accept) begin
      case (state_q)
        ST_IDLE: begin
          level_d = '0;
        end

        ST_ATTACK: begin
          if ((attack_step == '0) || (attack_sum >= {1'b0, LEVEL_MAX})) begin
            level_d = LEVEL_MAX;
            state_d = ST_DECAY;
          end else begin
            level_d = attack_sum[ENV_WIDTH-1:0];
          end
        end

        ST_DECAY: begin
          // Covers a step of zero and a sustain target at or above the current level
          if ((decay_step == '0) || ({1'b0, level_q} <= decay_floor)) begin
            level_d = sustain_level;
            state_d = ST_SUSTAIN;
          end else begin
            level_d = level_q - decay_step;
          end
        end

        ST_SUSTAIN: begin
          level_d = sustain_level;
        end

        ST_RELEASE: begin
          if ((release_step == '0) || (level_q <= release_step)) begin
            level_d    = '0;
            state_d    = ST_IDLE;
            finished_d = 1'b1;
          end else begin
            level_d = level_q - release_step;
          end
        end

        default: begin
          state_d = ST_IDLE;
          level_d = '0;
        end
      endcase
    end
  end

  // Envelope registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      level_q    <= '0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      finished_q <= finished_d;
    end
  end

  // Output sample register, held stable while downstream stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        sample_out_q <= sample_out_d;
      end
    end
  end

  assign s_if.sample_in_ready  = in_ready;
  assign s_if.sample_out       = sample_out_q;
  assign s_if.sample_out_valid = out_valid_q;
  assign level                 = level_q;
  assign state                 = state_q;
  assign note_finished         = finished_q;

endmodule

// File: tb/tb_note_envelope.sv
// tb/tb_note_envelope.sv - randomized and directed self-checking bench for note_envelope
module tb_note_envelope;

  logic        clk;
  logic        rst_n;
  logic        note_start;
  logic        note_release;
  logic        note_reset;
  logic [11:0] attack_step;
  logic [11:0] decay_step;
  logic [11:0] sustain_level;
  logic [11:0] release_step;
  logic [11:0] level;
  logic [2:0]  state;
  logic        note_finished;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_state;
  int m_level;
  int m_fin;
  int m_valid;
  int m_out;

  note_envelope_if #(.DATA_WIDTH(20)) dif ();

  note_envelope #(.DATA_WIDTH(20), .ENV_WIDTH(12)) dut (
    .clk           (clk),
    .rst           (rst_n),
    .s_if          (dif.slave),
    .note_start    (note_start),
    .note_release  (note_release),
    .note_reset    (note_reset),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .level         (level),
    .state         (state),
    .note_finished (note_finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_scale(input int s, input int l);
    longint p;
    longint q;
    p = longint'(s) * longint'(l);
    q = p / 4096;
    if ((p < 0) && ((p % 4096) != 0)) q = q - 1;
    return int'(q);
  endfunction

  task automatic model_reset();
    m_state = 0; m_level = 0; m_fin = 0; m_valid = 0; m_out = 0;
  endtask

  // Envelope behaviour from first principles: saturating add/subtract on integers
  task automatic model_edge(input int sin, input bit vin, input bit ordy,
                            input bit st, input bit rl, input bit nr);
    bit acc;
    int as, ds, sl, rs;
    as = int'(attack_step); ds = int'(decay_step);
    sl = int'(sustain_level); rs = int'(release_step);
    acc = vin && (!m_valid || ordy);
    if (acc) begin
      m_out   = floor_scale(sin, m_level);
      m_valid = 1;
    end else if (ordy) begin
      m_valid = 0;
    end
    if (nr) begin
      m_state = 0; m_level = 0; m_fin = 0;
    end else if (st) begin
      m_state = 1; m_fin = 0;
    end else if (rl) begin
      if (m_state >= 1 && m_state <= 3) m_state = 4;
    end else if (acc) begin
      case (m_state)
        0: m_level = 0;
        1: begin
          m_level = (as == 0) ? 4095 : ((m_level + as > 4095) ? 4095 : m_level + as);
          if (m_level == 4095) m_state = 2;
        end
        2: begin
          m_level = (ds == 0) ? sl : ((m_level - ds < sl) ? sl : m_level - ds);
          if (m_level == sl) m_state = 3;
        end
        3: m_level = sl;
        default: begin
          m_level = (rs == 0) ? 0 : ((m_level - rs < 0) ? 0 : m_level - rs);
          if (m_level == 0) begin
            m_state = 0; m_fin = 1;
          end
        end
      endcase
    end
  endtask

  task automatic cyc(input int sin, input bit vin, input bit ordy,
                     input bit st, input bit rl, input bit nr);
    @(negedge clk);
    dif.sample_in        = 20'(sin);
    dif.sample_in_valid  = vin;
    dif.sample_out_ready = ordy;
    note_start   = st;
    note_release = rl;
    note_reset   = nr;
    @(posedge clk);
    model_edge(sin, vin, ordy, st, rl, nr);
    #1;
    chk("state", int'(state), m_state);
    chk("level", int'(level), m_level);
    chk("finished", int'(note_finished), m_fin);
    chk("out_valid", int'(dif.sample_out_valid), m_valid);
    chk("out_data", int'($signed(dif.sample_out)), m_out);
    chk("in_ready", int'(dif.sample_in_ready), int'(!m_valid || ordy));
  endtask

  function automatic int rnd_sample();
    logic [19:0] r;
    r = 20'($urandom);
    return int'($signed(r));
  endfunction

  initial begin
    rst_n = 1'b0;
    dif.sample_in = '0; dif.sample_in_valid = 1'b0; dif.sample_out_ready = 1'b1;
    note_start = 1'b0; note_release = 1'b0; note_reset = 1'b0;
    attack_step = 12'd1024; decay_step = 12'd512;
    sustain_level = 12'd2048; release_step = 12'd1000;
    model_reset();
    #2;
    chk("rst_state", int'(state), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_valid", int'(dif.sample_out_valid), 0);
    chk("rst_out", int'($signed(dif.sample_out)), 0);
    chk("rst_fin", int'(note_finished), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // attack 1024 per sample up to full scale
    cyc(rnd_sample(), 1, 1, 1, 0, 0);
    chk("start_level", int'(level), 0);
    cyc(rnd_sample(), 1, 1, 0, 0, 0); chk("atk1", int'(level), 1024);
    cyc(rnd_sample(), 1, 1, 0, 0, 0); chk("atk2", int'(level), 2048);
    cyc(rnd_sample(), 1, 1, 0, 0, 0); chk("atk3", int'(level), 3072);
    cyc(rnd_sample(), 1, 1, 0, 0, 0); chk("atk4", int'(level), 4095);
    chk("to_decay", int'(state), 2);

    // decay to sustain; first decay sample scaled at full level
    cyc(100000, 1, 1, 0, 0, 0);
    chk("scale_pos", int'($signed(dif.sample_out)), 99975);
    chk("dec1", int'(level), 3583);
    cyc(rnd_sample(), 1, 1, 0, 0, 0); chk("dec2", int'(level), 3071);
    cyc(rnd_sample(), 1, 1, 0, 0, 0); chk("dec3", int'(level), 2559);
    cyc(rnd_sample(), 1, 1, 0, 0, 0); chk("dec4", int'(level), 2048);
    chk("to_sustain", int'(state), 3);

    // release to completion, then retrigger clears finished
    cyc(rnd_sample(), 1, 1, 0, 1, 0);
    chk("to_release", int'(state), 4);
    cyc(rnd_sample(), 1, 1, 0, 0, 0); chk("rel1", int'(level), 1048);
    cyc(rnd_sample(), 1, 1, 0, 0, 0); chk("rel2", int'(level), 48);
    cyc(rnd_sample(), 1, 1, 0, 0, 0); chk("rel3", int'(level), 0);
    chk("rel_idle", int'(state), 0);
    chk("fin_set", int'(note_finished), 1);
    cyc(rnd_sample(), 1, 1, 1, 0, 0);
    chk("fin_clear", int'(note_finished), 0);
    chk("restart_state", int'(state), 1);
    chk("restart_level", int'(level), 0);

    // instant attack, then negative sample at full level
    attack_step = 12'd0;
    cyc(rnd_sample(), 1, 1, 0, 0, 0);
    chk("inst_atk", int'(level), 4095);
    cyc(-100000, 1, 1, 0, 0, 0);
    chk("scale_neg", int'($signed(dif.sample_out)), -99976);

    // async reset in the middle of an attack
    attack_step = 12'd100;
    cyc(rnd_sample(), 1, 1, 1, 0, 0);
    cyc(rnd_sample(), 1, 1, 0, 0, 0);
    cyc(rnd_sample(), 1, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_state", int'(state), 0);
    chk("arst_level", int'(level), 0);
    chk("arst_valid", int'(dif.sample_out_valid), 0);
    chk("arst_fin", int'(note_finished), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // backpressure freezes the envelope and holds the output
    attack_step = 12'd300;
    cyc(rnd_sample(), 1, 1, 1, 0, 0);
    cyc(rnd_sample(), 1, 1, 0, 0, 0);
    cyc(rnd_sample(), 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(rnd_sample(), 1, 0, 0, 0, 0);
      chk("stall_level", int'(level), 600);
      chk("stall_ready", int'(dif.sample_in_ready), 0);
    end
    cyc(rnd_sample(), 1, 1, 0, 0, 0);
    chk("resume1", int'(level), 900);
    cyc(rnd_sample(), 1, 1, 0, 0, 0);
    chk("resume2", int'(level), 1200);

    // retrigger from release continues from the current level
    attack_step = 12'd1500; release_step = 12'd100;
    cyc(rnd_sample(), 1, 1, 0, 0, 1);
    cyc(rnd_sample(), 1, 1, 1, 0, 0);
    cyc(rnd_sample(), 1, 1, 0, 0, 0);
    cyc(rnd_sample(), 1, 1, 0, 1, 0);
    chk("rel_1500", int'(level), 1500);
    cyc(rnd_sample(), 1, 1, 1, 0, 0);
    chk("retrig_state", int'(state), 1);
    chk("retrig_level", int'(level), 1500);
    attack_step = 12'd10;
    cyc(rnd_sample(), 1, 1, 0, 0, 0);
    chk("retrig_step", int'(level), 1510);
    cyc(rnd_sample(), 1, 1, 0, 1, 0);
    cyc(rnd_sample(), 1, 1, 1, 0, 1);
    chk("rst_win_state", int'(state), 0);
    chk("rst_win_level", int'(level), 0);

    // randomized traffic, live step changes and sporadic control pulses
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        attack_step   = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 800));
        decay_step    = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 800));
        sustain_level = 12'($urandom);
        release_step  = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 800));
      end
      cyc(rnd_sample(),
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 39) == 0,
          $urandom_range(0, 24) == 0,
          $urandom_range(0, 99) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_envelope.md
Name: note_envelope

Overview:
- Per-note ADSR amplitude envelope inserted between the NCO scaler/summer output (20-bit signed sum) and the global gain truncator.
- Receives note_start / note_release / note_reset pulses decoded by the memory-mapped I/O block and reports note_finished back to it for CPU polling.
- Advances the envelope once per sample accepted over a valid/ready stream, so envelope timing tracks the synth sample rate.

Parameters:
DATA_WIDTH, 20, width of signed sample in/out
ENV_WIDTH, 12, width of unsigned envelope level; full scale = 2^ENV_WIDTH-1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
sample_in  input  DATA_WIDTH  signed sample from summer
sample_in_valid  input  1  sample_in valid
sample_in_ready  output  1  block can accept sample
sample_out  output  DATA_WIDTH  enveloped signed sample to truncator
sample_out_valid  output  1  sample_out valid
sample_out_ready  input  1  downstream accepts
note_start  input  1  one-cycle pulse: (re)trigger note
note_release  input  1  one-cycle pulse: key released
note_reset  input  1  one-cycle pulse: abort to IDLE
attack_step  input  ENV_WIDTH  level increment per sample; 0 = instant
decay_step  input  ENV_WIDTH  level decrement per sample; 0 = instant
sustain_level  input  ENV_WIDTH  sustain target
release_step  input  ENV_WIDTH  level decrement per sample; 0 = instant
level  output  ENV_WIDTH  current envelope level
state  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
note_finished  output  1  sticky: release reached 0

Behaviour:
- Reset (rst low, async): state=IDLE, level=0, note_finished=0, sample_out=0, sample_out_valid=0.
- Handshake: sample_in_ready = !sample_out_valid || sample_out_ready (combinational). Accept = sample_in_valid && sample_in_ready. On accept: sample_out registered, sample_out_valid=1, latency 1 cycle. Valid deasserts when downstream accepts with no new input. sample_out held stable while valid && !ready.
- Arithmetic: sample_out = (sample_in * {1'b0,level}) >>> ENV_WIDTH, signed product of DATA_WIDTH+ENV_WIDTH+1 bits, arithmetic shift (floor), low DATA_WIDTH bits kept. Uses level value before the same-edge update.
- Control priority per edge: note_reset > note_start > note_release > per-sample step.
- note_reset: state=IDLE, level=0, note_finished=0. Output register/handshake untouched.
- note_start (any state): state=ATTACK, level unchanged (retrigger without click), note_finished=0; no step applied that edge.
- note_release: from ATTACK/DECAY/SUSTAIN -> RELEASE, level unchanged; ignored in IDLE and RELEASE.
- Per-sample step (only on accept, no control pulse same edge):
  - IDLE: level=0, stay.
  - ATTACK: level = min(level+attack_step, max) (compute with carry bit); step 0 -> level=max. On reaching max -> DECAY.
  - DECAY: level = max(level-decay_step, sustain_level) (no underflow); step 0 -> sustain_level. When result == sustain_level -> SUSTAIN. If sustain_level >= level on entry: level=sustain_level, -> SUSTAIN.
  - SUSTAIN: level = sustain_level (tracks live changes).
  - RELEASE: level = max(level-release_step, 0); step 0 -> 0. On 0 -> IDLE, note_finished=1.
- No accept -> level and state frozen (backpressure stalls envelope). Control pulses act regardless of accept.
- note_finished stays 1 until note_start or note_reset; coincident with release completion, start/reset win.
- Step inputs sampled live each accept; no internal copies.

Test Plan:
- Reset mid-ATTACK (rst low async, no clock edge) -> state=0, level=0, sample_out_valid=0, note_finished=0 immediately.
- attack_step=1024, out_ready=1, valid every cycle, note_start -> level 1024, 2048, 3072, 4095 on successive accepts, then state=DECAY.
- In DECAY, decay_step=512, sustain_level=2048 -> level 3583, 3071, 2559, 2048, state=SUSTAIN; sample_in=100000 at level 4095 -> sample_out=99975; sample_in=-100000 -> -99976.
- In SUSTAIN at 2048, release_step=1000, note_release -> RELEASE; level 1048, 48, 0; state=IDLE; note_finished=1; then note_start -> finished=0, state=ATTACK, level=0.
- sample_out_ready=0 for 5 cycles with valid input -> sample_out_valid=1 held, sample_in_ready=0, level/state frozen, sample_out unchanged; ready=1 -> resumes one step per accept.
- note_reset and note_start same cycle in RELEASE -> IDLE, level=0; note_start alone in RELEASE at level 1500 -> ATTACK continuing from 1500.
